// File: rtl/adc_level_meter.sv
// adc_level_meter: converts a signed ADC sample stream into an LED level display.
// Samples are quantised to an LED index in stage 1 and rendered in stage 2 as
// DOT, BAR, FREEZE or OFF. A sticky overrange flag marks clipped samples.
// Optional feature macro: LEVEL_METER_PEAK_HOLD_EN adds a decaying peak marker.
module adc_level_meter #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BIT_OFFSET       = 0,
  parameter int LED_COUNT        = 8,
  parameter int HOLD_CYCLES      = 125000000,
  parameter int DECAY_CYCLES     = 12500000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  input  logic [1:0]                  mode,
  input  logic                        ovr_clr,
  output logic [LED_COUNT-1:0]        led_out,
  output logic                        ovr
);

  localparam int K        = $clog2(LED_COUNT);
  localparam int TOP      = ADC_WIDTH - 1;
  localparam int CODE_MSB = ADC_WIDTH - BIT_OFFSET - 1;

  localparam logic [K-1:0]         MID_IDX  = K'(LED_COUNT / 2);
  localparam logic [K-1:0]         POS_FULL = K'(LED_COUNT / 2 - 1);
  localparam logic [K-1:0]         NEG_FULL = K'(LED_COUNT - 1);
  localparam logic [LED_COUNT-1:0] ALL_ON   = '1;
  localparam logic [LED_COUNT-1:0] ONE_LED  = LED_COUNT'(1);

  typedef enum logic [1:0] {
    MODE_DOT    = 2'b00,
    MODE_BAR    = 2'b01,
    MODE_FREEZE = 2'b10,
    MODE_OFF    = 2'b11
  } mode_t;

  mode_t                 disp_mode;
  logic [K-1:0]          code;
  logic [BIT_OFFSET:0]   top_bits;
  logic                  sat;
  logic [K-1:0]          new_idx;
  logic [K-1:0]          idx_q;
  logic                  valid_q;
  logic                  lamp_done;
  logic [LED_COUNT-1:0]  led_next;
  logic [LED_COUNT-1:0]  peak_mask;
  logic                  unused_tdata;

  assign disp_mode    = mode_t'(mode);
  assign unused_tdata = ^S_AXIS_tdata;

  // Quantise the sample: the skipped MSBs must agree with the sign, otherwise clip to an end LED
  always_comb begin
    code     = S_AXIS_tdata[CODE_MSB -: K];
    top_bits = S_AXIS_tdata[TOP -: BIT_OFFSET + 1];
    sat      = (|top_bits) & ~(&top_bits);
    if (sat) begin
      new_idx = S_AXIS_tdata[TOP] ? NEG_FULL : '0;
    end else begin
      new_idx = POS_FULL - code;
    end
  end

  // Stage 1: hold the index of the latest accepted sample and flag when one was taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= MID_IDX;
      valid_q <= 1'b0;
    end else begin
      valid_q <= S_AXIS_tvalid;
      if (S_AXIS_tvalid) begin
        idx_q <= new_idx;
      end
    end
  end

  // Sticky overrange flag; a clipping sample wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr <= 1'b0;
    end else if (S_AXIS_tvalid && sat) begin
      ovr <= 1'b1;
    end else if (ovr_clr) begin
      ovr <= 1'b0;
    end
  end

  // Lamp test ends once the first accepted sample has been rendered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamp_done <= 1'b0;
    end else if (valid_q) begin
      lamp_done <= 1'b1;
    end
  end

`ifdef LEVEL_METER_PEAK_HOLD_EN
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int DECAY_W = $clog2(DECAY_CYCLES + 1);

  logic [K-1:0]       peak;
  logic               peak_valid;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [DECAY_W-1:0] decay_cnt;
  logic [K-1:0]       cur_idx;

  assign cur_idx   = S_AXIS_tvalid ? new_idx : idx_q;
  assign peak_mask = peak_valid ? (ONE_LED << peak) : '0;

  // Peak tracker: louder (or equal) samples reload and re-hold, then the peak walks back one LED per decay step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak       <= '0;
      peak_valid <= 1'b0;
      hold_cnt   <= '0;
      decay_cnt  <= '0;
    end else if (S_AXIS_tvalid && (!peak_valid || new_idx <= peak)) begin
      peak       <= new_idx;
      peak_valid <= 1'b1;
      hold_cnt   <= HOLD_W'(HOLD_CYCLES);
      decay_cnt  <= '0;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end else if (peak_valid && peak < cur_idx) begin
      if (decay_cnt == '0) begin
        peak      <= peak + 1'b1;
        decay_cnt <= DECAY_W'(DECAY_CYCLES - 1);
      end else begin
        decay_cnt <= decay_cnt - 1'b1;
      end
    end
  end
`else
  localparam int UNUSED_PEAK_PARAMS = HOLD_CYCLES + DECAY_CYCLES;

  assign peak_mask = '0;
`endif

  // Stage 2 pattern: lamp test until the first sample lands, otherwise render the latest index per mode
  always_comb begin
    led_next = led_out;
    if (!lamp_done && !valid_q) begin
      led_next = ALL_ON;
    end else begin
      case (disp_mode)
        MODE_DOT:    led_next = (ONE_LED << idx_q) | peak_mask;
        MODE_BAR:    led_next = (ALL_ON << idx_q) | peak_mask;
        MODE_FREEZE: led_next = led_out;
        MODE_OFF:    led_next = '0;
        default:     led_next = led_out;
      endcase
    end
  end

  // Stage 2 register drives the LEDs; reset lights every LED
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= ALL_ON;
    end else begin
      led_out <= led_next;
    end
  end

endmodule

// File: tb/tb_adc_level_meter.sv
// tb_adc_level_meter: directed bench for adc_level_meter with a sample-level reference model.
// Default build checks two configurations (BIT_OFFSET 0 and 4); with
// LEVEL_METER_PEAK_HOLD_EN defined it checks the peak-hold walk instead.
module tb_adc_level_meter;

  localparam logic [1:0] DOT = 2'b00;
  localparam logic [1:0] BAR = 2'b01;
  localparam logic [1:0] FRZ = 2'b10;
  localparam logic [1:0] OFF = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic        tvalid;
  logic [1:0]  mode;
  logic        ovr_clr;
  int          total = 0;
  int          bad = 0;

  // Free-running 100 MHz-style bench clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [13:0] d, input logic [1:0] m,
                               input logic c, input int cycles);
    tvalid  = v;
    tdata   = {18'b0, d};
    mode    = m;
    ovr_clr = c;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

`ifndef LEVEL_METER_PEAK_HOLD_EN
  logic [7:0] led0, led4;
  logic       ovr0, ovr4;
  logic       check_en = 1'b0;

  adc_level_meter dut0 (
    .clk(clk), .rst(rst), .S_AXIS_tdata(tdata), .S_AXIS_tvalid(tvalid),
    .mode(mode), .ovr_clr(ovr_clr), .led_out(led0), .ovr(ovr0)
  );

  adc_level_meter #(.BIT_OFFSET(4)) dut4 (
    .clk(clk), .rst(rst), .S_AXIS_tdata(tdata), .S_AXIS_tvalid(tvalid),
    .mode(mode), .ovr_clr(ovr_clr), .led_out(led4), .ovr(ovr4)
  );

  // Full scale of the visible window is 2^(13-b); the 8 LEDs split it into steps of 2^(11-b)
  function automatic int model_idx(input logic [13:0] d, input int b);
    int v;
    int fs;
    v  = int'($signed(d));
    fs = 1 << (13 - b);
    if (v >= fs) return 0;
    if (v < -fs) return 7;
    return 3 - (v >>> (11 - b));
  endfunction

  function automatic bit model_sat(input logic [13:0] d, input int b);
    int v;
    int fs;
    v  = int'($signed(d));
    fs = 1 << (13 - b);
    return (v >= fs) || (v < -fs);
  endfunction

  bit         have[2];
  int         last[2];
  logic [7:0] exp_led[2];
  logic       exp_ovr[2];

  // Reference: LEDs show the most recent sample taken before this edge, rendered per current mode
  always @(posedge clk or posedge rst) begin
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        have[j]    <= 1'b0;
        last[j]    <= 0;
        exp_led[j] <= 8'hFF;
        exp_ovr[j] <= 1'b0;
      end else begin
        if (!have[j]) begin
          exp_led[j] <= 8'hFF;
        end else begin
          case (mode)
            DOT: exp_led[j] <= 8'h01 << last[j];
            BAR: exp_led[j] <= 8'hFF << last[j];
            FRZ: exp_led[j] <= exp_led[j];
            OFF: exp_led[j] <= 8'h00;
            default: exp_led[j] <= exp_led[j];
          endcase
        end
        if (tvalid && model_sat(tdata[13:0], j * 4)) begin
          exp_ovr[j] <= 1'b1;
        end else if (ovr_clr) begin
          exp_ovr[j] <= 1'b0;
        end
        if (tvalid) begin
          have[j] <= 1'b1;
          last[j] <= model_idx(tdata[13:0], j * 4);
        end
      end
    end
  end

  // Compare both DUTs against the reference on every falling edge
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_led0", led0, exp_led[0]);
      checkOutput("model_ovr0", {7'b0, ovr0}, {7'b0, exp_ovr[0]});
      checkOutput("model_led4", led4, exp_led[1]);
      checkOutput("model_ovr4", {7'b0, ovr4}, {7'b0, exp_ovr[1]});
    end
  end

  logic [13:0] sweep [12];

  initial begin
    sweep = '{14'h0000, 14'h07FF, 14'h0800, 14'h17FF, 14'h1800, 14'h3800,
              14'h37FF, 14'h2800, 14'h01FF, 14'h3E00, 14'h0200, 14'h3DFF};
    rst = 1'b1; tvalid = 1'b0; tdata = '0; mode = DOT; ovr_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_led0", led0, 8'hFF);
    checkOutput("reset_ovr4", {7'b0, ovr4}, 8'h00);
    check_en = 1'b1;
    rst = 1'b0;

    applyStimulus(0, 14'h0000, DOT, 0, 100);
    checkOutput("idle_led0", led0, 8'hFF);
    checkOutput("idle_ovr0", {7'b0, ovr0}, 8'h00);

    applyStimulus(1, 14'h1FFF, DOT, 0, 1);
    checkOutput("lamp_hold_led0", led0, 8'hFF);
    checkOutput("sat_pos_ovr4", {7'b0, ovr4}, 8'h01);
    applyStimulus(1, 14'h2000, DOT, 0, 1);
    checkOutput("dot_top_led0", led0, 8'h01);
    applyStimulus(0, 14'h0000, DOT, 0, 1);
    checkOutput("dot_bottom_led0", led0, 8'h80);

    applyStimulus(1, 14'h0000, BAR, 0, 1);
    applyStimulus(0, 14'h0000, BAR, 0, 1);
    checkOutput("bar_zero_led0", led0, 8'hF8);
    applyStimulus(1, 14'h3FFF, BAR, 0, 1);
    applyStimulus(0, 14'h0000, BAR, 0, 1);
    checkOutput("bar_minus1_led0", led0, 8'hF0);
    checkOutput("bar_minus1_led4", led4, 8'hF0);

    applyStimulus(0, 14'h0000, DOT, 1, 1);
    checkOutput("clr_ovr4", {7'b0, ovr4}, 8'h00);
    applyStimulus(1, 14'h1000, DOT, 0, 1);
    checkOutput("ovr_set_ovr4", {7'b0, ovr4}, 8'h01);
    applyStimulus(1, 14'h0000, DOT, 0, 1);
    checkOutput("clip_led4", led4, 8'h01);
    checkOutput("unclipped_led0", led0, 8'h02);
    applyStimulus(0, 14'h0000, DOT, 0, 1);
    checkOutput("ovr_sticky_ovr4", {7'b0, ovr4}, 8'h01);
    checkOutput("dot_mid_led0", led0, 8'h08);
    applyStimulus(0, 14'h0000, DOT, 1, 1);
    checkOutput("ovr_cleared_ovr4", {7'b0, ovr4}, 8'h00);

    applyStimulus(1, 14'h1000, DOT, 1, 1);
    checkOutput("set_beats_clr_ovr4", {7'b0, ovr4}, 8'h01);
    applyStimulus(1, 14'h0000, DOT, 1, 1);
    checkOutput("clr_no_sat_ovr4", {7'b0, ovr4}, 8'h00);
    applyStimulus(0, 14'h0000, DOT, 0, 2);
    checkOutput("pre_freeze_led0", led0, 8'h08);

    applyStimulus(1, 14'h1FFF, FRZ, 0, 4);
    checkOutput("freeze_led0", led0, 8'h08);
    applyStimulus(0, 14'h0000, DOT, 0, 1);
    checkOutput("unfreeze_led0", led0, 8'h01);

    applyStimulus(0, 14'h0000, OFF, 1, 1);
    checkOutput("off_led0", led0, 8'h00);
    applyStimulus(1, 14'h2000, OFF, 0, 2);
    checkOutput("off_still_led0", led0, 8'h00);
    checkOutput("off_ovr_updates_ovr4", {7'b0, ovr4}, 8'h01);

    applyStimulus(1, 14'h1FFF, DOT, 0, 1);
    rst = 1'b1;
    #1;
    checkOutput("midpipe_rst_led0", led0, 8'hFF);
    checkOutput("midpipe_rst_ovr4", {7'b0, ovr4}, 8'h00);
    tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 14'h0000, DOT, 0, 5);
    checkOutput("no_stale_led0", led0, 8'hFF);

    for (int i = 0; i < 12; i++) begin
      applyStimulus((i % 4) != 3, sweep[i], (i % 2 == 1) ? BAR : DOT, i == 7, 1);
    end
    applyStimulus(0, 14'h0000, DOT, 0, 3);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

`else
  logic [7:0] ledp;
  logic       ovrp;

  adc_level_meter #(.HOLD_CYCLES(10), .DECAY_CYCLES(4)) dutp (
    .clk(clk), .rst(rst), .S_AXIS_tdata(tdata), .S_AXIS_tvalid(tvalid),
    .mode(mode), .ovr_clr(ovr_clr), .led_out(ledp), .ovr(ovrp)
  );

  // Peak sequence: one loud sample, then mid-scale forever; the marker holds then walks home
  initial begin
    logic [7:0] want;
    rst = 1'b1; tvalid = 1'b0; tdata = '0; mode = DOT; ovr_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ledp", ledp, 8'hFF);
    checkOutput("reset_ovrp", {7'b0, ovrp}, 8'h00);
    rst = 1'b0;
    applyStimulus(0, 14'h0000, DOT, 0, 2);
    applyStimulus(1, 14'h1FFF, DOT, 0, 1);
    applyStimulus(1, 14'h0000, DOT, 0, 1);
    checkOutput("peak_first_ledp", ledp, 8'h01);
    for (int e = 3; e <= 24; e++) begin
      applyStimulus(1, 14'h0000, DOT, 0, 1);
      if (e <= 12)      want = 8'h09;
      else if (e <= 16) want = 8'h0A;
      else if (e <= 20) want = 8'h0C;
      else              want = 8'h08;
      checkOutput($sformatf("peak_walk_e%0d", e), ledp, want);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
`endif

endmodule
